// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: phase kinds, lane and mode codes, and the
// chunking / lane-mapping helpers used by the command sequencer.
package qspi_pkg;

  typedef enum logic [2:0] {
    PhCmd   = 3'd0,
    PhAddr  = 3'd1,
    PhDummy = 3'd2,
    PhWdata = 3'd3,
    PhRdata = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    LaneX1 = 2'd0,
    LaneX2 = 2'd1,
    LaneX4 = 2'd2
  } lane_t;

  typedef enum logic [1:0] {
    Mode111 = 2'd0,
    Mode112 = 2'd1,
    Mode114 = 2'd2,
    Mode144 = 2'd3
  } mode_t;

  // Bytes in the next data chunk: min(remaining, 4).
  function automatic logic [2:0] chunk_bytes(input logic [31:0] rem);
    return (rem >= 32'd4) ? 3'd4 : rem[2:0];
  endfunction

  function automatic lane_t addr_lanes(input logic [1:0] mode);
    return (mode_t'(mode) == Mode144) ? LaneX4 : LaneX1;
  endfunction

  function automatic lane_t data_lanes(input logic [1:0] mode);
    lane_t lanes;
    unique case (mode_t'(mode))
      Mode111: lanes = LaneX1;
      Mode112: lanes = LaneX2;
      default: lanes = LaneX4;
    endcase
    return lanes;
  endfunction

  // Keep only the upper bytes that belong to a partial chunk.
  function automatic logic [31:0] mask_chunk(input logic [31:0] data, input logic [2:0] nbytes);
    logic [31:0] res;
    unique case (nbytes)
      3'd1:    res = {data[31:24], 24'h0};
      3'd2:    res = {data[31:16], 16'h0};
      3'd3:    res = {data[31:8], 8'h0};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/qspi_cmd_sequencer.sv
// QSPI command sequencer: breaks a flash transaction into CMD/ADDR/DUMMY/data
// segments for a downstream shifter and collects read words back.
module qspi_cmd_sequencer
  import qspi_pkg::*;
#(
  parameter int unsigned LEN_W   = 9,
  parameter int unsigned DUMMY_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [7:0]         cmd_i,
  input  logic [31:0]        addr_i,
  input  logic               addr_en_i,
  input  logic               addr4_i,
  input  logic [DUMMY_W-1:0] dummy_i,
  input  logic               rd_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [1:0]         mode_i,
  input  logic [31:0]        wdata_i,
  input  logic               wdata_valid_i,
  output logic               wdata_ready_o,
  output logic [31:0]        rdata_o,
  output logic               rdata_valid_o,
  output logic               seg_valid_o,
  input  logic               seg_ready_i,
  output logic [31:0]        seg_data_o,
  output logic [5:0]         seg_bits_o,
  output logic [1:0]         seg_lanes_o,
  output logic [2:0]         seg_kind_o,
  output logic               seg_last_o,
  input  logic               rx_valid_i,
  input  logic [31:0]        rx_data_i,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StRwait, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [31:0]        addr_q, addr_d;
  logic               addr_en_q, addr_en_d;
  logic               addr4_q, addr4_d;
  logic [DUMMY_W-1:0] dummy_q, dummy_d;
  logic               rd_q, rd_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;

  logic        seg_valid, seg_last, seg_hs, last_chunk;
  logic [31:0] seg_data;
  logic [5:0]  seg_bits;
  lane_t       seg_lanes;
  phase_t      seg_kind;
  logic [2:0]  chunk;
  state_e      st_data, st_after_addr, st_after_cmd;

  assign chunk      = chunk_bytes(32'(rem_q));
  assign last_chunk = 32'(rem_q) <= 32'd4;

  // Successor phases with absent phases skipped; DONE means nothing follows.
  assign st_data       = (rem_q != '0) ? (rd_q ? StRdata : StWdata) : StDone;
  assign st_after_addr = (dummy_q != '0) ? StDummy : st_data;
  assign st_after_cmd  = addr_en_q ? StAddr : st_after_addr;

  always_comb begin
    seg_valid = 1'b0;
    seg_data  = '0;
    seg_bits  = '0;
    seg_lanes = LaneX1;
    seg_kind  = PhCmd;
    seg_last  = 1'b0;
    unique case (state_q)
      StCmd: begin
        seg_valid = 1'b1;
        seg_data  = {cmd_q, 24'h0};
        seg_bits  = 6'd8;
        seg_last  = (st_after_cmd == StDone);
      end
      StAddr: begin
        seg_valid = 1'b1;
        seg_data  = addr4_q ? addr_q : {addr_q[23:0], 8'h0};
        seg_bits  = addr4_q ? 6'd32 : 6'd24;
        seg_lanes = addr_lanes(mode_q);
        seg_kind  = PhAddr;
        seg_last  = (st_after_addr == StDone);
      end
      StDummy: begin
        seg_valid = 1'b1;
        seg_bits  = 6'(dummy_q);
        seg_lanes = addr_lanes(mode_q);
        seg_kind  = PhDummy;
        seg_last  = (st_data == StDone);
      end
      StWdata: begin
        seg_valid = wdata_valid_i;
        seg_data  = wdata_i;
        seg_bits  = {chunk, 3'b000};
        seg_lanes = data_lanes(mode_q);
        seg_kind  = PhWdata;
        seg_last  = last_chunk;
      end
      StRdata: begin
        seg_valid = 1'b1;
        seg_bits  = {chunk, 3'b000};
        seg_lanes = data_lanes(mode_q);
        seg_kind  = PhRdata;
        seg_last  = last_chunk;
      end
      default: ;
    endcase
  end

  assign seg_hs = seg_valid && seg_ready_i;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    addr_en_d     = addr_en_q;
    addr4_d       = addr4_q;
    dummy_d       = dummy_q;
    rd_d          = rd_q;
    rem_d         = rem_q;
    mode_d        = mode_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cmd_d     = cmd_i;
          addr_d    = addr_i;
          addr_en_d = addr_en_i;
          addr4_d   = addr4_i;
          dummy_d   = dummy_i;
          rd_d      = rd_i;
          rem_d     = len_i;
          mode_d    = mode_i;
          state_d   = StCmd;
        end
      end
      StCmd:   if (seg_hs) state_d = st_after_cmd;
      StAddr:  if (seg_hs) state_d = st_after_addr;
      StDummy: if (seg_hs) state_d = st_data;
      StWdata: begin
        if (seg_hs) begin
          rem_d   = rem_q - LEN_W'(chunk);
          state_d = last_chunk ? StDone : StWdata;
        end
      end
      StRdata: if (seg_hs) state_d = StRwait;
      StRwait: begin
        if (rx_valid_i) begin
          rdata_d       = mask_chunk(rx_data_i, chunk);
          rdata_valid_d = 1'b1;
          rem_d         = rem_q - LEN_W'(chunk);
          state_d       = last_chunk ? StDone : StRdata;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      addr_q        <= '0;
      addr_en_q     <= 1'b0;
      addr4_q       <= 1'b0;
      dummy_q       <= '0;
      rd_q          <= 1'b0;
      rem_q         <= '0;
      mode_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      addr_en_q     <= addr_en_d;
      addr4_q       <= addr4_d;
      dummy_q       <= dummy_d;
      rd_q          <= rd_d;
      rem_q         <= rem_d;
      mode_q        <= mode_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign seg_valid_o   = seg_valid;
  assign seg_data_o    = seg_data;
  assign seg_bits_o    = seg_bits;
  assign seg_lanes_o   = seg_lanes;
  assign seg_kind_o    = seg_kind;
  assign seg_last_o    = seg_last;
  assign wdata_ready_o = (state_q == StWdata) && seg_hs;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Directed bench for qspi_cmd_sequencer; the bench plays the shifter side.
module tb_qspi_cmd_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  cmd_i = '0;
  logic [31:0] addr_i = '0;
  logic        addr_en_i = 1'b0;
  logic        addr4_i = 1'b0;
  logic [4:0]  dummy_i = '0;
  logic        rd_i = 1'b0;
  logic [8:0]  len_i = '0;
  logic [1:0]  mode_i = '0;
  logic [31:0] wdata_i = '0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        seg_valid_o;
  logic        seg_ready_i = 1'b0;
  logic [31:0] seg_data_o;
  logic [5:0]  seg_bits_o;
  logic [1:0]  seg_lanes_o;
  logic [2:0]  seg_kind_o;
  logic        seg_last_o;
  logic        rx_valid_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  qspi_cmd_sequencer #(.LEN_W(9), .DUMMY_W(5)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .cmd_i         (cmd_i),
    .addr_i        (addr_i),
    .addr_en_i     (addr_en_i),
    .addr4_i       (addr4_i),
    .dummy_i       (dummy_i),
    .rd_i          (rd_i),
    .len_i         (len_i),
    .mode_i        (mode_i),
    .wdata_i       (wdata_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .seg_valid_o   (seg_valid_o),
    .seg_ready_i   (seg_ready_i),
    .seg_data_o    (seg_data_o),
    .seg_bits_o    (seg_bits_o),
    .seg_lanes_o   (seg_lanes_o),
    .seg_kind_o    (seg_kind_o),
    .seg_last_o    (seg_last_o),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input logic [7:0] cmd, input logic [31:0] addr, input logic aen,
                        input logic a4, input logic [4:0] dum, input logic rd,
                        input logic [8:0] len, input logic [1:0] mode);
    cmd_i = cmd; addr_i = addr; addr_en_i = aen; addr4_i = a4;
    dummy_i = dum; rd_i = rd; len_i = len; mode_i = mode;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Waits (bounded) for a segment, checks every field, then accepts it.
  task automatic do_seg(input string tag, input logic [31:0] d, input logic [5:0] b,
                        input logic [1:0] l, input logic [2:0] k, input logic last);
    int n = 0;
    while (!seg_valid_o && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(seg_valid_o), 64'd1);
    if (seg_valid_o) begin
      check({tag, "_data"}, 64'(seg_data_o), 64'(d));
      check({tag, "_bits"}, 64'(seg_bits_o), 64'(b));
      check({tag, "_lanes"}, 64'(seg_lanes_o), 64'(l));
      check({tag, "_kind"}, 64'(seg_kind_o), 64'(k));
      check({tag, "_last"}, 64'(seg_last_o), 64'(last));
      seg_ready_i = 1'b1;
      #1;
      check({tag, "_wready"}, 64'(wdata_ready_o), (k == 3'd3) ? 64'd1 : 64'd0);
      tick();
      seg_ready_i = 1'b0;
    end
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    tick();
    check({tag, "_done_end"}, 64'(done_o), 64'd0);
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic rx_word(input logic [31:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
  endtask

  initial begin
    int dones;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_segv", 64'(seg_valid_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rdv", 64'(rdata_valid_o), 64'd0);
    rst_n_i = 1'b1;
    tick();

    // Write-enable: command-only
    launch(8'h06, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 9'd0, 2'd0);
    do_seg("wren_cmd", 32'h0600_0000, 6'd8, 2'd0, 3'd0, 1'b1);
    expect_done("wren");

    // Quad read 1-4-4, 3-byte address, 6 dummies, 5 bytes
    launch(8'hEB, 32'h0012_3456, 1'b1, 1'b0, 5'd6, 1'b1, 9'd5, 2'd3);
    rx_valid_i = 1'b1;
    rx_data_i  = 32'hFFFF_FFFF;
    tick();
    rx_valid_i = 1'b0;
    check("qrd_rx_ignored", 64'(rdata_valid_o), 64'd0);
    check("qrd_still_cmd", 64'(seg_kind_o), 64'd0);
    do_seg("qrd_cmd", 32'hEB00_0000, 6'd8, 2'd0, 3'd0, 1'b0);
    do_seg("qrd_addr", 32'h1234_5600, 6'd24, 2'd2, 3'd1, 1'b0);
    do_seg("qrd_dummy", 32'h0, 6'd6, 2'd2, 3'd2, 1'b0);
    do_seg("qrd_rd0", 32'h0, 6'd32, 2'd2, 3'd4, 1'b0);
    check("qrd_rwait_segv", 64'(seg_valid_o), 64'd0);
    rx_word(32'hA1B2_C3D4);
    check("qrd_rdv0", 64'(rdata_valid_o), 64'd1);
    check("qrd_rdata0", 64'(rdata_o), 64'hA1B2_C3D4);
    do_seg("qrd_rd1", 32'h0, 6'd8, 2'd2, 3'd4, 1'b1);
    rx_word(32'h5566_7788);
    check("qrd_rdv1", 64'(rdata_valid_o), 64'd1);
    check("qrd_rdata1", 64'(rdata_o), 64'h5500_0000);
    expect_done("qrd");
    check("qrd_rdv_pulse", 64'(rdata_valid_o), 64'd0);

    // Page program, 4-byte address, write data withheld 5 cycles
    launch(8'h02, 32'h0000_1000, 1'b1, 1'b1, 5'd0, 1'b0, 9'd8, 2'd0);
    do_seg("pp_cmd", 32'h0200_0000, 6'd8, 2'd0, 3'd0, 1'b0);
    do_seg("pp_addr", 32'h0000_1000, 6'd32, 2'd0, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("pp_withheld", 64'(seg_valid_o), 64'd0);
      tick();
    end
    wdata_i = 32'hDEAD_BEEF;
    wdata_valid_i = 1'b1;
    #1;
    do_seg("pp_w0", 32'hDEAD_BEEF, 6'd32, 2'd0, 3'd3, 1'b0);
    wdata_i = 32'hCAFE_F00D;
    #1;
    do_seg("pp_w1", 32'hCAFE_F00D, 6'd32, 2'd0, 3'd3, 1'b1);
    wdata_valid_i = 1'b0;
    expect_done("pp");

    // Partial write chunk on x4 lanes
    launch(8'h32, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 9'd3, 2'd2);
    do_seg("w3_cmd", 32'h3200_0000, 6'd8, 2'd0, 3'd0, 1'b0);
    wdata_i = 32'hAABB_CCDD;
    wdata_valid_i = 1'b1;
    #1;
    do_seg("w3_data", 32'hAABB_CCDD, 6'd24, 2'd2, 3'd3, 1'b1);
    wdata_valid_i = 1'b0;
    expect_done("w3");

    // Backpressure during ADDR; input address changes must not leak through
    launch(8'h03, 32'h00AB_CDEF, 1'b1, 1'b0, 5'd0, 1'b1, 9'd2, 2'd0);
    do_seg("bp_cmd", 32'h0300_0000, 6'd8, 2'd0, 3'd0, 1'b0);
    addr_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 64'(seg_valid_o), 64'd1);
      check("bp_hold_data", 64'(seg_data_o), 64'hABCD_EF00);
      check("bp_hold_kind", 64'(seg_kind_o), 64'd1);
      tick();
    end
    do_seg("bp_addr", 32'hABCD_EF00, 6'd24, 2'd0, 3'd1, 1'b0);
    do_seg("bp_rd", 32'h0, 6'd16, 2'd0, 3'd4, 1'b1);
    rx_word(32'h1122_3344);
    check("bp_rdata", 64'(rdata_o), 64'h1122_0000);
    expect_done("bp");

    // Reset while waiting for read return
    launch(8'h0B, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1, 9'd4, 2'd1);
    do_seg("rr_cmd", 32'h0B00_0000, 6'd8, 2'd0, 3'd0, 1'b0);
    do_seg("rr_dummy", 32'h0, 6'd8, 2'd0, 3'd2, 1'b0);
    do_seg("rr_rd", 32'h0, 6'd32, 2'd1, 3'd4, 1'b1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rr_busy", 64'(busy_o), 64'd0);
    check("rr_segv", 64'(seg_valid_o), 64'd0);
    check("rr_rdata", 64'(rdata_o), 64'd0);
    check("rr_done", 64'(done_o), 64'd0);
    rx_valid_i = 1'b1;
    rx_data_i  = 32'h1234_5678;
    tick();
    tick();
    rst_n_i = 1'b1;
    rx_valid_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o || busy_o || rdata_valid_o) dones++;
      tick();
    end
    check("rr_quiet_after", 64'(dones), 64'd0);
    launch(8'h06, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 9'd0, 2'd0);
    do_seg("rr_again", 32'h0600_0000, 6'd8, 2'd0, 3'd0, 1'b1);
    expect_done("rr_again");

    // start_i held high throughout: back-to-back transactions
    cmd_i = 8'h06; addr_en_i = 1'b0; dummy_i = 5'd0; len_i = 9'd0; mode_i = 2'd0;
    start_i = 1'b1;
    tick();
    do_seg("hold_cmd0", 32'h0600_0000, 6'd8, 2'd0, 3'd0, 1'b1);
    check("hold_done0", 64'(done_o), 64'd1);
    tick();
    check("hold_idle_gap", 64'(busy_o), 64'd0);
    tick();
    check("hold_restart", 64'(seg_valid_o), 64'd1);
    start_i = 1'b0;
    do_seg("hold_cmd1", 32'h0600_0000, 6'd8, 2'd0, 3'd0, 1'b1);
    expect_done("hold1");
    tick();
    check("hold_no_third", 64'(busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_cmd_sequencer.md
QSPI_CMD_SEQUENCER -- requirements
Module: qspi_cmd_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 9, meaning width of the data byte count (maximum 2^LEN_W-1 bytes).
REQ-002 SHALL have parameter DUMMY_W, default 5, meaning width of the dummy-cycle count.
REQ-003 SHALL use one clock, clk_i, and reset rst_n_i, which is asynchronous and active-low.
REQ-004 SHALL have these ports, each listed as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- start_i  in  1  transaction request; sampled in IDLE only
- cmd_i  in  8  opcode
- addr_i  in  32  flash address
- addr_en_i  in  1  address phase present
- addr4_i  in  1  1 = 4-byte address, 0 = 3-byte address
- dummy_i  in  DUMMY_W  dummy cycles; 0 = no dummy phase
- rd_i  in  1  1 = read data phase, 0 = write data phase
- len_i  in  LEN_W  data bytes; 0 = no data phase
- mode_i  in  2  lane mode: 0 = 1-1-1, 1 = 1-1-2, 2 = 1-1-4, 3 = 1-4-4
- wdata_i / wdata_valid_i / wdata_ready_o  in / in / out  32 / 1 / 1  write-word stream
- rdata_o / rdata_valid_o  out / out  32 / 1  read-word output
- seg_valid_o / seg_ready_i  out / in  1 / 1  segment handshake to the shifter
- seg_data_o  out  32  segment payload; MSB-aligned, bit 31 shifted first
- seg_bits_o  out  6  bits (or dummy cycles) in the segment, 1..32
- seg_lanes_o  out  2  lane code: 0 = x1, 1 = x2, 2 = x4
- seg_kind_o  out  3  phase type, qspi_pkg::phase_t
- seg_last_o  out  1  last segment of the transaction; the shifter releases CS after it
- rx_valid_i / rx_data_i  in / in  1 / 32  shifter read return, MSB-aligned
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement states IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, RWAIT and DONE.
REQ-006 SHALL, when start_i is high in IDLE, latch all transaction inputs and enter CMD on the next edge; seg_valid_o SHALL be high in the following cycle.
REQ-007 SHALL ignore start_i in every state other than IDLE.
REQ-008 SHALL advance a phase only on seg_valid_o && seg_ready_i; phase order is CMD, ADDR, DUMMY, data, with absent phases skipped: ADDR if addr_en_i=0, DUMMY if dummy_i=0, data if len_i=0.
REQ-009 SHALL, in CMD, drive 8 bits of payload {cmd, 24'h0} on x1 lanes.
REQ-010 SHALL, in ADDR, drive 24 bits {addr[23:0], 8'h0} or 32 bits of addr; lanes SHALL be x4 when mode=3 and x1 otherwise.
REQ-011 SHALL, in DUMMY, drive seg_bits_o = dummy count and seg_data_o = 0, using the same lanes as ADDR.
REQ-012 SHALL split the data phase into chunks of min(remaining,4) bytes, with seg_bits_o = 8 × chunk size; data lanes SHALL be x1 for mode 0, x2 for mode 1 and x4 for modes 2 and 3.
REQ-013 SHALL, in WDATA, hold seg_valid_o low until wdata_valid_i is high; payload SHALL be wdata_i, with partial chunks using the upper bytes; wdata_ready_o SHALL be high only on a WDATA segment handshake.
REQ-014 SHALL, in RDATA, move to RWAIT after the handshake; on rx_valid_i it SHALL output rdata_o = rx_data_i with unused low bytes forced to 0, pulse rdata_valid_o for 1 cycle, and either issue the next chunk or finish.
REQ-015 SHALL ignore rx_valid_i outside RWAIT.
REQ-016 SHALL hold seg_data_o and the other segment outputs stable while seg_valid_o is high and seg_ready_i is low.
REQ-017 SHALL assert seg_last_o on the final segment only; for a command-only transaction that is the CMD segment.
REQ-018 SHALL pulse done_o for 1 cycle in DONE, after the last handshake or, for reads, after the last rx_valid_i; the next state SHALL be IDLE, so a new start is accepted 1 cycle after done_o.
REQ-019 SHALL keep the remaining-byte counter LEN_W wide, decrementing it by the chunk size; it SHALL never underflow.
REQ-020 SHALL treat an accepted len_i not a multiple of 4 as a final partial chunk (e.g. len = 5 gives chunks of 4 and 1).

Reset
REQ-021 SHALL, on rst_n_i low, immediately force state IDLE, and all outputs and counters to 0.
REQ-022 SHALL, on reset mid-transaction, abort without a done_o pulse; the shifter is responsible for deasserting CS.

Structure
REQ-023 SHALL place phase_t (CMD, ADDR, DUMMY, WDATA, RDATA), the lane codes and the mode codes in the shared package qspi_pkg.
REQ-024 SHALL be a single module with no sub-modules; the chunk-size and lane-mapping logic SHALL be package functions.

Verification
REQ-025 Write-enable: cmd=06h, no address, no dummy, no data -> one segment {06h, 24'h0}, bits 8, seg_last_o=1, then done_o.
REQ-026 Quad read: cmd=EBh, mode=3, 3-byte addr=123456h, dummy=6, rd, len=5 -> ADDR segment 24 bits x4; DUMMY segment 6; RDATA chunks of 32 and 8 bits; second rdata_o = {rx[31:24], 24'h0}.
REQ-027 Page program: cmd=02h, 4-byte addr=0000_1000h, len=8, wdata_valid_i withheld 5 cycles -> seg_valid_o stays low for those cycles, then two 32-bit x1 segments, the second with seg_last_o=1.
REQ-028 Backpressure: seg_ready_i low 10 cycles during ADDR -> payload stable throughout, with no phase skip.
REQ-029 Reset asserted in RWAIT -> all outputs 0 asynchronously; no done_o; a new start after reset completes normally.
REQ-030 start_i held high through a whole transaction -> exactly one transaction, then a second starting 1 cycle after done_o.
